// File: rtl/boiler_pkg.sv
// Shared definitions for the colour-sort boiler: colour codes, stack depth and
// the pour FSM encoding.
package boiler_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  typedef logic [CW-1:0] colour_t;

  localparam colour_t COL_EMPTY     = 3'b000;
  localparam colour_t COL_PINK      = 3'b001;
  localparam colour_t COL_BLUE      = 3'b010;
  localparam colour_t COL_ORANGE    = 3'b011;
  localparam colour_t COL_GREEN     = 3'b100;
  localparam colour_t COL_PURPLE    = 3'b101;
  localparam colour_t COL_LIGHTGREY = 3'b110;
  localparam colour_t COL_INVALID   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPour = 2'b01,
    StDone = 2'b10
  } state_e;

  // A code that may occupy a slot: anything but empty or invalid.
  function automatic logic is_legal(input colour_t c);
    return (c != COL_EMPTY) && (c != COL_INVALID);
  endfunction

endpackage

// File: rtl/boiler_run_calc.sv
// Derives top colour, length of the top run and the solved flag from the
// current slot contents.
module boiler_run_calc
  import boiler_pkg::*;
(
  input  logic [DEPTH-1:0][CW-1:0] i_slots,
  input  logic [2:0]               i_count,
  output logic [CW-1:0]            o_top_colour,
  output logic [2:0]               o_top_run,
  output logic                     o_solved
);

  logic [1:0] w_top_idx;
  logic       w_stop;
  logic       w_all_same;

  assign w_top_idx = i_count[1:0] - 2'd1;

  always_comb begin
    o_top_colour = COL_EMPTY;
    if (i_count != 3'd0) begin
      o_top_colour = i_slots[w_top_idx];
    end
  end

  // Walk down from the top slot until the colour changes.
  always_comb begin
    o_top_run = 3'd0;
    w_stop    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < int'(i_count)) begin
        if (!w_stop && (i_slots[i] == o_top_colour)) begin
          o_top_run = o_top_run + 3'd1;
        end else begin
          w_stop = 1'b1;
        end
      end
    end
  end

  assign w_all_same = (i_slots[0] == i_slots[1]) && (i_slots[1] == i_slots[2]) &&
                      (i_slots[2] == i_slots[3]);

  assign o_solved = (i_count == 3'd0) || ((i_count == 3'(DEPTH)) && w_all_same);

endmodule

// File: rtl/boiler_stack.sv
// Layer store for one boiler: level load, single-layer pushes and a
// valid/ready stream of the top run towards a destination boiler.
module boiler_stack
  import boiler_pkg::*;
#(
  parameter bit STRICT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [11:0]   i_load_colours,
  input  logic          i_sel_toggle,
  input  logic          i_sel_clear,
  output logic          o_selected,
  input  logic          i_push_valid,
  input  logic [CW-1:0] i_push_colour,
  output logic          o_push_ready,
  input  logic          i_pour_start,
  input  logic [2:0]    i_pour_max,
  output logic          o_out_valid,
  output logic [CW-1:0] o_out_colour,
  input  logic          i_out_ready,
  output logic          o_pour_done,
  output logic [2:0]    o_pour_count,
  output logic [CW-1:0] o_colour1,
  output logic [CW-1:0] o_colour2,
  output logic [CW-1:0] o_colour3,
  output logic [CW-1:0] o_colour4,
  output logic [2:0]    o_count,
  output logic [CW-1:0] o_top_colour,
  output logic [2:0]    o_top_run,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_solved,
  output logic          o_err
);

  logic [DEPTH-1:0][CW-1:0] r_slots_q, w_slots_d;
  logic [2:0]               r_count_q, w_count_d;
  state_e                   r_state_q, w_state_d;
  logic [2:0]               r_n_q, w_n_d;
  logic [2:0]               r_moved_q, w_moved_d;
  logic                     r_sel_q, w_sel_d;
  logic                     r_err_q, w_err_d;
  logic                     r_done_q, w_done_d;
  logic [2:0]               r_pcount_q, w_pcount_d;

  logic [CW-1:0] w_top_colour;
  logic [2:0]    w_top_run;
  logic          w_solved;
  logic          w_push_hs;
  logic          w_push_bad;
  logic [2:0]    w_pour_n;
  logic [1:0]    w_top_idx;
  logic          w_gap;
  logic [CW-1:0] w_lc;

  boiler_run_calc u_run_calc (
    .i_slots      (r_slots_q),
    .i_count      (r_count_q),
    .o_top_colour (w_top_colour),
    .o_top_run    (w_top_run),
    .o_solved     (w_solved)
  );

  assign o_full       = (r_count_q == 3'(DEPTH));
  assign o_empty      = (r_count_q == 3'd0);
  assign o_push_ready = (r_state_q == StIdle) && !o_full && !i_load && !i_pour_start;

  assign w_push_hs  = i_push_valid && o_push_ready;
  assign w_push_bad = !is_legal(i_push_colour) ||
                      (STRICT && (r_count_q != 3'd0) && (i_push_colour != w_top_colour));
  assign w_pour_n   = (w_top_run < i_pour_max) ? w_top_run : i_pour_max;
  assign w_top_idx  = r_count_q[1:0] - 2'd1;

  always_comb begin
    w_slots_d  = r_slots_q;
    w_count_d  = r_count_q;
    w_state_d  = r_state_q;
    w_n_d      = r_n_q;
    w_moved_d  = r_moved_q;
    w_sel_d    = r_sel_q;
    w_err_d    = 1'b0;
    w_done_d   = 1'b0;
    w_pcount_d = 3'd0;
    w_gap      = 1'b0;
    w_lc       = COL_EMPTY;

    if (i_sel_clear) begin
      w_sel_d = 1'b0;
    end else if (i_sel_toggle) begin
      w_sel_d = ~r_sel_q;
    end

    if (i_load) begin
      // Keep the legal prefix from the bottom; anything past the first gap is dropped.
      w_count_d = 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        w_lc = i_load_colours[i*CW +: CW];
        if (!w_gap && is_legal(w_lc)) begin
          w_slots_d[i] = w_lc;
          w_count_d    = w_count_d + 3'd1;
        end else begin
          w_gap        = 1'b1;
          w_slots_d[i] = COL_EMPTY;
          if (w_lc != COL_EMPTY) begin
            w_err_d = 1'b1;
          end
        end
      end
      w_state_d = StIdle;
      w_moved_d = 3'd0;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          if (w_push_hs) begin
            if (w_push_bad) begin
              w_err_d = 1'b1;
            end else begin
              w_slots_d[r_count_q[1:0]] = i_push_colour;
              w_count_d                 = r_count_q + 3'd1;
            end
          end else if (i_pour_start) begin
            w_n_d     = w_pour_n;
            w_moved_d = 3'd0;
            if (w_pour_n == 3'd0) begin
              w_done_d = 1'b1;
            end else begin
              w_state_d = StPour;
            end
          end
        end
        StPour: begin
          if (i_out_ready) begin
            w_slots_d[w_top_idx] = COL_EMPTY;
            w_count_d            = r_count_q - 3'd1;
            w_moved_d            = r_moved_q + 3'd1;
            if (w_moved_d == r_n_q) begin
              w_state_d  = StDone;
              w_done_d   = 1'b1;
              w_pcount_d = r_n_q;
            end
          end
        end
        StDone: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots_q  <= '0;
      r_count_q  <= 3'd0;
      r_state_q  <= StIdle;
      r_n_q      <= 3'd0;
      r_moved_q  <= 3'd0;
      r_sel_q    <= 1'b0;
      r_err_q    <= 1'b0;
      r_done_q   <= 1'b0;
      r_pcount_q <= 3'd0;
    end else begin
      r_slots_q  <= w_slots_d;
      r_count_q  <= w_count_d;
      r_state_q  <= w_state_d;
      r_n_q      <= w_n_d;
      r_moved_q  <= w_moved_d;
      r_sel_q    <= w_sel_d;
      r_err_q    <= w_err_d;
      r_done_q   <= w_done_d;
      r_pcount_q <= w_pcount_d;
    end
  end

  assign o_selected   = r_sel_q;
  assign o_out_valid  = (r_state_q == StPour);
  assign o_out_colour = o_out_valid ? w_top_colour : COL_EMPTY;
  assign o_pour_done  = r_done_q;
  assign o_pour_count = r_pcount_q;
  assign o_err        = r_err_q;
  assign o_count      = r_count_q;
  assign o_top_colour = w_top_colour;
  assign o_top_run    = w_top_run;
  assign o_solved     = w_solved;
  assign o_colour1    = r_slots_q[0];
  assign o_colour2    = r_slots_q[1];
  assign o_colour3    = r_slots_q[2];
  assign o_colour4    = r_slots_q[3];

endmodule

// File: tb/tb_boiler_stack.sv
// Bench for boiler_stack: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_boiler_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_load = 1'b0;
  logic [11:0] i_load_colours = '0;
  logic        i_sel_toggle = 1'b0;
  logic        i_sel_clear = 1'b0;
  logic        i_push_valid = 1'b0;
  logic [2:0]  i_push_colour = '0;
  logic        i_pour_start = 1'b0;
  logic [2:0]  i_pour_max = '0;
  logic        i_out_ready = 1'b0;

  logic       o_selected, o_push_ready, o_out_valid, o_pour_done;
  logic       o_full, o_empty, o_solved, o_err;
  logic [2:0] o_out_colour, o_pour_count, o_count, o_top_colour, o_top_run;
  logic [2:0] o_colour1, o_colour2, o_colour3, o_colour4;

  boiler_stack #(.STRICT(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (i_load),
    .i_load_colours (i_load_colours),
    .i_sel_toggle   (i_sel_toggle),
    .i_sel_clear    (i_sel_clear),
    .o_selected     (o_selected),
    .i_push_valid   (i_push_valid),
    .i_push_colour  (i_push_colour),
    .o_push_ready   (o_push_ready),
    .i_pour_start   (i_pour_start),
    .i_pour_max     (i_pour_max),
    .o_out_valid    (o_out_valid),
    .o_out_colour   (o_out_colour),
    .i_out_ready    (i_out_ready),
    .o_pour_done    (o_pour_done),
    .o_pour_count   (o_pour_count),
    .o_colour1      (o_colour1),
    .o_colour2      (o_colour2),
    .o_colour3      (o_colour3),
    .o_colour4      (o_colour4),
    .o_count        (o_count),
    .o_top_colour   (o_top_colour),
    .o_top_run      (o_top_run),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_solved       (o_solved),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue, bottom at index 0.
  int m_stk[$];
  bit m_sel = 1'b0;
  int m_phase = 0;  // 0 idle, 1 pouring, 2 done
  int m_n = 0;
  int m_moved = 0;
  bit m_err = 1'b0;
  bit m_done = 1'b0;
  int m_pcount = 0;

  function automatic int m_top();
    return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
  endfunction

  function automatic int m_run();
    int r = 0;
    for (int i = m_stk.size() - 1; i >= 0; i--) begin
      if (m_stk[i] != m_top()) break;
      r++;
    end
    return r;
  endfunction

  function automatic int m_slot(input int i);
    return (i < m_stk.size()) ? m_stk[i] : 0;
  endfunction

  function automatic bit m_solved();
    if (m_stk.size() == 0) return 1'b1;
    if (m_stk.size() != 4) return 1'b0;
    return (m_run() == 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int c;
    int lim;
    bit gap;
    if (!rst_n) begin
      m_stk.delete();
      m_sel = 0; m_phase = 0; m_n = 0; m_moved = 0;
      m_err = 0; m_done = 0; m_pcount = 0;
    end else begin
      m_err = 0; m_done = 0; m_pcount = 0;
      if (i_sel_clear) m_sel = 0;
      else if (i_sel_toggle) m_sel = !m_sel;
      if (i_load) begin
        m_stk.delete();
        gap = 0;
        for (int i = 0; i < 4; i++) begin
          c = int'(i_load_colours[3*i +: 3]);
          if (!gap && c != 0 && c != 7) m_stk.push_back(c);
          else begin
            gap = 1;
            if (c != 0) m_err = 1;
          end
        end
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (i_push_valid && m_stk.size() < 4 && !i_pour_start) begin
          c = int'(i_push_colour);
          if (c == 0 || c == 7 || (m_stk.size() > 0 && c != m_top())) m_err = 1;
          else m_stk.push_back(c);
        end else if (i_pour_start) begin
          lim = int'(i_pour_max);
          m_n = (m_run() < lim) ? m_run() : lim;
          m_moved = 0;
          if (m_n == 0) m_done = 1;
          else m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (i_out_ready) begin
          void'(m_stk.pop_back());
          m_moved++;
          if (m_moved == m_n) begin
            m_phase = 2; m_done = 1; m_pcount = m_n;
          end
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("colour1", o_colour1, m_slot(0));
      chk("colour2", o_colour2, m_slot(1));
      chk("colour3", o_colour3, m_slot(2));
      chk("colour4", o_colour4, m_slot(3));
      chk("count", o_count, m_stk.size());
      chk("top_colour", o_top_colour, m_top());
      chk("top_run", o_top_run, m_run());
      chk("full", o_full, m_stk.size() == 4);
      chk("empty", o_empty, m_stk.size() == 0);
      chk("solved", o_solved, m_solved());
      chk("selected", o_selected, m_sel);
      chk("err", o_err, m_err);
      chk("out_valid", o_out_valid, m_phase == 1);
      if (m_phase == 1) chk("out_colour", o_out_colour, m_top());
      chk("pour_done", o_pour_done, m_done);
      if (m_done) chk("pour_count", o_pour_count, m_pcount);
      chk("push_ready", o_push_ready,
          (m_phase == 0) && (m_stk.size() < 4) && !i_load && !i_pour_start);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] lc);
    i_load = 1'b1;
    i_load_colours = lc;
    tick();
    i_load = 1'b0;
  endtask

  logic [11:0] lc;
  int rc;
  int rk;

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_solved", o_solved, 1);
    chk("rst_selected", o_selected, 0);

    // Load with a two-deep orange run on top of pink.
    do_load(12'b000_011_011_001);
    chk("load_count", o_count, 3);
    chk("load_top", o_top_colour, 3'b011);
    chk("load_run", o_top_run, 2);
    chk("load_err", o_err, 0);
    chk("load_solved", o_solved, 0);

    // Pour of at most one layer.
    i_pour_start = 1'b1; i_pour_max = 3'd1; i_out_ready = 1'b1;
    tick();
    i_pour_start = 1'b0;
    chk("p1_valid", o_out_valid, 1);
    chk("p1_colour", o_out_colour, 3'b011);
    tick();
    chk("p1_done", o_pour_done, 1);
    chk("p1_pcount", o_pour_count, 1);
    chk("p1_count", o_count, 2);
    tick();

    // Strict mismatch rejected, matching push accepted.
    do_load(12'b000_000_000_001);
    i_push_valid = 1'b1; i_push_colour = 3'b010;
    tick();
    i_push_valid = 1'b0;
    chk("mis_err", o_err, 1);
    chk("mis_count", o_count, 1);
    i_push_valid = 1'b1; i_push_colour = 3'b001;
    tick();
    i_push_valid = 1'b0;
    chk("ok_count", o_count, 2);
    chk("ok_run", o_top_run, 2);
    chk("ok_err", o_err, 0);

    // Stalled pour of two layers.
    i_out_ready = 1'b0; i_pour_max = 3'd4; i_pour_start = 1'b1;
    tick();
    i_pour_start = 1'b0;
    repeat (3) begin
      chk("stall_valid", o_out_valid, 1);
      chk("stall_colour", o_out_colour, 3'b001);
      chk("stall_count", o_count, 2);
      tick();
    end
    i_out_ready = 1'b1;
    tick();
    chk("drain_count", o_count, 1);
    tick();
    chk("drain_done", o_pour_done, 1);
    chk("drain_pcount", o_pour_count, 2);
    chk("drain_count0", o_count, 0);
    tick();

    // Load aborts a pour in progress.
    do_load(12'b000_100_100_100);
    i_pour_start = 1'b1; i_pour_max = 3'd3;
    tick();
    i_pour_start = 1'b0;
    tick();
    chk("abort_pre_count", o_count, 2);
    do_load(12'b000_000_010_110);
    chk("abort_valid", o_out_valid, 0);
    chk("abort_count", o_count, 2);
    chk("abort_c1", o_colour1, 3'b110);
    chk("abort_c2", o_colour2, 3'b010);
    chk("abort_done", o_pour_done, 0);
    tick();
    chk("abort_done2", o_pour_done, 0);

    // Illegal load: invalid code forms the gap, non-zero above it.
    do_load(12'b001_000_111_010);
    chk("ill_count", o_count, 1);
    chk("ill_err", o_err, 1);
    chk("ill_c4", o_colour4, 0);

    // Fill with purple.
    do_load(12'b0);
    i_push_valid = 1'b1; i_push_colour = 3'b101;
    repeat (4) tick();
    chk("fill_full", o_full, 1);
    chk("fill_solved", o_solved, 1);
    chk("fill_ready", o_push_ready, 0);
    tick();
    i_push_valid = 1'b0;
    chk("fill5_count", o_count, 4);
    chk("fill5_err", o_err, 0);

    // Reset in the middle of a pour.
    do_load(12'b000_000_101_101);
    i_pour_start = 1'b1; i_pour_max = 3'd2; i_out_ready = 1'b0;
    tick();
    i_pour_start = 1'b0;
    chk("rp_valid", o_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rp_valid0", o_out_valid, 0);
    chk("rp_count0", o_count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rp_done", o_pour_done, 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      i_load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) begin
        rc = $urandom_range(1, 6);
        rk = $urandom_range(0, 4);
        lc = '0;
        for (int j = 0; j < rk; j++) lc[3*j +: 3] = 3'(rc);
      end else begin
        lc = 12'($urandom);
      end
      i_load_colours = lc;
      i_push_valid = 1'($urandom_range(0, 1));
      if (m_stk.size() > 0 && $urandom_range(0, 2) != 0) i_push_colour = 3'(m_top());
      else i_push_colour = 3'($urandom_range(0, 7));
      i_pour_start = ($urandom_range(0, 5) == 0);
      i_pour_max = 3'($urandom_range(0, 4));
      i_out_ready = ($urandom_range(0, 3) != 0);
      i_sel_toggle = ($urandom_range(0, 7) == 0);
      i_sel_clear = ($urandom_range(0, 15) == 0);
      tick();
    end
    i_load = 1'b0; i_push_valid = 1'b0; i_pour_start = 1'b0;
    i_sel_toggle = 1'b0; i_sel_clear = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
